// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame geometry, default
// baud divisor, the transmitter state encoding and a counter-width helper.
package uart_pkg;

    // Payload bits carried by one 8N1 frame.
    localparam int NUM_DATA_BITS = 8;

    // 100 MHz system clock divided down to 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    // Transmitter FSM encoding; the binary values are fixed so that the
    // receptor side and debug tooling see the same numbering.
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START_BIT = 2'd1,
        S_DATA_BITS = 2'd2,
        S_STOP_BIT  = 2'd3
    } tx_state_t;

    // Width of a counter that must hold 0..clks-1; never narrower than 1 bit.
    function automatic int baud_cnt_width(input int clks);
        return (clks <= 2) ? 1 : $clog2(clks);
    endfunction

endpackage

// File: rtl/generador_baudios.sv
// Baud-rate generator: a modulo-CLKS_PER_BIT counter that flags the last
// clock cycle of every serial bit. Held at zero while clear is high so each
// frame starts on a fresh bit boundary.
module generador_baudios
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int               CNT_W    = baud_cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             tick_s;

    // Last cycle of the current bit period.
    always_comb begin
        tick_s = (cnt_r == CNT_LAST);
    end

    assign tick = tick_s;

    // Bit-period counter: wraps at the bit boundary, parked at zero on clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (tick_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/transmisor_serial.sv
// UART transmitter, 8N1, LSB first, line idling high. Accepts one byte per
// start request while idle and serialises it at CLKS_PER_BIT clocks per bit.
// tx, busy and done are all registered; done pulses for one cycle in the
// cycle the FSM is back in IDLE, so a new request can be taken right there.
module transmisor_serial
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = NUM_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int               IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    tx_state_t            state_r;
    tx_state_t            state_nxt_s;
    logic [DATA_BITS-1:0] shreg_r;
    logic [DATA_BITS-1:0] shreg_nxt_s;
    logic [IDX_W-1:0]     idx_r;
    logic [IDX_W-1:0]     idx_nxt_s;
    logic                 tx_r;
    logic                 tx_nxt_s;
    logic                 busy_r;
    logic                 busy_nxt_s;
    logic                 done_r;
    logic                 done_nxt_s;
    logic                 baud_clear_s;
    logic                 baud_tick_s;

    // Keep the baud counter parked while idle so every frame starts aligned.
    always_comb begin
        baud_clear_s = (state_r == S_IDLE);
    end

    generador_baudios #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baudios (
        .clk   (clk),
        .reset (reset),
        .clear (baud_clear_s),
        .tick  (baud_tick_s)
    );

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so that the registered tx lines up exactly with the state it belongs to.
    always_comb begin
        state_nxt_s = state_r;
        shreg_nxt_s = shreg_r;
        idx_nxt_s   = idx_r;
        tx_nxt_s    = tx_r;
        busy_nxt_s  = busy_r;
        done_nxt_s  = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    shreg_nxt_s = data;
                    idx_nxt_s   = {IDX_W{1'b0}};
                    state_nxt_s = S_START_BIT;
                    tx_nxt_s    = 1'b0;
                    busy_nxt_s  = 1'b1;
                end else begin
                    tx_nxt_s    = 1'b1;
                    busy_nxt_s  = 1'b0;
                end
            end

            S_START_BIT: begin
                if (baud_tick_s) begin
                    state_nxt_s = S_DATA_BITS;
                    idx_nxt_s   = {IDX_W{1'b0}};
                    tx_nxt_s    = shreg_r[0];
                end else begin
                    tx_nxt_s    = 1'b0;
                end
            end

            S_DATA_BITS: begin
                if (baud_tick_s) begin
                    shreg_nxt_s = shreg_r >> 1;
                    idx_nxt_s   = idx_r + IDX_W'(1);
                    if (idx_r == LAST_IDX) begin
                        state_nxt_s = S_STOP_BIT;
                        tx_nxt_s    = 1'b1;
                    end else begin
                        // The bit about to be presented is the one that moves
                        // into position 0 on this same edge.
                        tx_nxt_s    = shreg_r[1];
                    end
                end else begin
                    tx_nxt_s = shreg_r[0];
                end
            end

            S_STOP_BIT: begin
                tx_nxt_s = 1'b1;
                if (baud_tick_s) begin
                    state_nxt_s = S_IDLE;
                    busy_nxt_s  = 1'b0;
                    done_nxt_s  = 1'b1;
                end else begin
                    busy_nxt_s  = 1'b1;
                end
            end

            default: begin
                state_nxt_s = S_IDLE;
                tx_nxt_s    = 1'b1;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            shreg_r <= {DATA_BITS{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            shreg_r <= shreg_nxt_s;
            idx_r   <= idx_nxt_s;
            tx_r    <= tx_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign tx   = tx_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_transmisor_serial.sv
// Bench for transmisor_serial: a fast instance (4 clocks/bit) for the
// protocol cases and a 868 clocks/bit instance for the 115200-baud loopback.
// Stimulus pushes the bytes it expects on the line; independent monitors
// decode the tx line like a receptor, pop and compare on each done pulse.
module tb_transmisor_serial;

    localparam int CPB_F = 4;
    localparam int CPB_S = 868;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_f, start_s;
    logic [7:0] data_f, data_s;
    logic       tx_f, busy_f, done_f;
    logic       tx_s, busy_s, done_s;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_f[$];
    logic [7:0] exp_s[$];

    always #5 clk = ~clk;

    transmisor_serial #(.CLKS_PER_BIT(CPB_F), .DATA_BITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start_f),
        .data  (data_f),
        .tx    (tx_f),
        .busy  (busy_f),
        .done  (done_f)
    );

    transmisor_serial #(.CLKS_PER_BIT(CPB_S), .DATA_BITS(8)) dut_slow (
        .clk   (clk),
        .reset (reset),
        .start (start_s),
        .data  (data_s),
        .tx    (tx_s),
        .busy  (busy_s),
        .done  (done_s)
    );

    task automatic check(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Receptor model: called on the first negedge where tx is low. Samples
    // each of the 10 bits mid-period, counts busy cycles and the distance
    // to done. Gives up if reset is seen or done does not arrive in time.
    task automatic rx_frame(input bit slow, output logic [9:0] bits, output int len,
                            output int bcnt, output bit aborted, output bit got_done);
        int cpb;
        int n;
        cpb      = slow ? CPB_S : CPB_F;
        bits     = 10'h3FF;
        n        = 0;
        len      = 0;
        bcnt     = 0;
        aborted  = 1'b0;
        got_done = 1'b0;
        while (n <= 10 * cpb + 2 && !got_done && !aborted) begin
            if (reset) begin
                aborted = 1'b1;
            end else begin
                if ((slow ? busy_s : busy_f) == 1'b1) bcnt++;
                if ((n % cpb) == cpb / 2 && (n / cpb) < 10) bits[n / cpb] = slow ? tx_s : tx_f;
                if ((slow ? done_s : done_f) == 1'b1) begin
                    got_done = 1'b1;
                    len      = n;
                end else begin
                    @(negedge clk);
                    n++;
                end
            end
        end
    endtask

    task automatic monitor(input bit slow);
        logic [9:0] bits;
        logic [7:0] e;
        int         len, bcnt, cpb, qsz;
        bit         aborted, got_done;
        cpb = slow ? CPB_S : CPB_F;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if ((slow ? tx_s : tx_f) == 1'b0) begin
                    rx_frame(slow, bits, len, bcnt, aborted, got_done);
                    if (!aborted) begin
                        check(slow ? "slow_done_seen" : "fast_done_seen", int'(got_done), 1);
                        qsz = slow ? exp_s.size() : exp_f.size();
                        check(slow ? "slow_frame_expected" : "fast_frame_expected", int'(qsz > 0), 1);
                        if (got_done && qsz > 0) begin
                            if (slow) e = exp_s.pop_front();
                            else      e = exp_f.pop_front();
                            check(slow ? "slow_byte" : "fast_byte", int'(bits[8:1]), int'(e));
                            check("start_bit", int'(bits[0]), 0);
                            check("stop_bit", int'(bits[9]), 1);
                            check("frame_len", len, 10 * cpb);
                            check("busy_len", bcnt, 10 * cpb);
                        end
                    end
                end else begin
                    check(slow ? "slow_idle_status" : "fast_idle_status",
                          int'({slow ? busy_s : busy_f, slow ? done_s : done_f}), 0);
                end
            end
        end
    endtask

    initial monitor(1'b0);
    initial monitor(1'b1);

    task automatic send(input bit slow, input logic [7:0] b);
        @(posedge clk);
        #1;
        if (slow) begin
            start_s = 1'b1;
            data_s  = b;
            exp_s.push_back(b);
        end else begin
            start_f = 1'b1;
            data_f  = b;
            exp_f.push_back(b);
        end
        @(posedge clk);
        #1;
        start_s = 1'b0;
        start_f = 1'b0;
    endtask

    task automatic wait_done(input bit slow, input int bound, input string name);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        while (n < bound && !got) begin
            @(negedge clk);
            if ((slow ? done_s : done_f) == 1'b1) got = 1'b1;
            n++;
        end
        check(name, int'(got), 1);
    endtask

    task automatic count_dones(input int cycles, output int dcount);
        dcount = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done_f) dcount++;
        end
    endtask

    initial begin
        int dcount;
        reset   = 1'b1;
        start_f = 1'b0;
        start_s = 1'b0;
        data_f  = 8'h00;
        data_s  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state_fast", int'({tx_f, busy_f, done_f}), 3'b100);
        check("reset_state_slow", int'({tx_s, busy_s, done_s}), 3'b100);
        @(posedge clk);
        #1 reset = 1'b0;

        // 1: idle line after reset
        repeat (20) begin
            @(negedge clk);
            check("idle_20", int'({tx_f, busy_f, done_f}), 3'b100);
        end

        // 2: single 0x55 frame
        send(1'b0, 8'h55);
        wait_done(1'b0, 60, "t2_done");
        repeat (5) @(posedge clk);

        // 3: start held high, data changed mid-frame, back-to-back second frame
        @(posedge clk);
        #1;
        start_f = 1'b1;
        data_f  = 8'hA3;
        exp_f.push_back(8'hA3);
        repeat (16) @(posedge clk);
        #1;
        data_f = 8'hFF;
        exp_f.push_back(8'hFF);
        wait_done(1'b0, 60, "t3_done_a");
        check("t3_start_in_done_cycle", int'(start_f), 1);
        @(posedge clk);
        #1 start_f = 1'b0;
        @(negedge clk);
        check("t3_b2b_start", int'({tx_f, busy_f}), 2'b01);
        wait_done(1'b0, 60, "t3_done_b");
        repeat (5) @(posedge clk);

        // 4: reset during data bit 3 of 0x0F, then a clean frame
        @(posedge clk);
        #1;
        start_f = 1'b1;
        data_f  = 8'h0F;
        @(posedge clk);
        #1 start_f = 1'b0;
        repeat (17) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t4_after_reset", int'({tx_f, busy_f, done_f}), 3'b100);
        count_dones(60, dcount);
        check("t4_no_done", dcount, 0);
        send(1'b0, 8'h0F);
        wait_done(1'b0, 60, "t4_clean_done");

        // 5: start pulse while busy is ignored
        send(1'b0, 8'h3C);
        repeat (10) @(posedge clk);
        #1;
        start_f = 1'b1;
        data_f  = 8'h99;
        @(posedge clk);
        #1 start_f = 1'b0;
        wait_done(1'b0, 60, "t5_done");
        count_dones(60, dcount);
        check("t5_single_done", dcount, 0);

        // 6: 115200-baud loopback bytes
        send(1'b1, 8'h00);
        wait_done(1'b1, 10 * CPB_S + 20, "t6_done_00");
        send(1'b1, 8'hFF);
        wait_done(1'b1, 10 * CPB_S + 20, "t6_done_ff");
        send(1'b1, 8'hA3);
        wait_done(1'b1, 10 * CPB_S + 20, "t6_done_a3");

        repeat (10) @(negedge clk);
        check("fast_queue_empty", exp_f.size(), 0);
        check("slow_queue_empty", exp_s.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
